// File: rtl/intr_cond_sync.sv
// Multi-channel interrupt conditioner: synchronises async sources, detects
// level/edge events per channel, holds W1C pending bits and masks the outputs.
module intr_cond_sync #(
    parameter int INTR_WIDTH = 4,
    parameter int SYNC_STAGE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INTR_WIDTH-1:0]   intr_in,
    input  logic [2*INTR_WIDTH-1:0] intr_mode,
    input  logic [INTR_WIDTH-1:0]   intr_en,
    input  logic [INTR_WIDTH-1:0]   intr_clr,
    output logic [INTR_WIDTH-1:0]   intr_pend,
    output logic [INTR_WIDTH-1:0]   intr_evt,
    output logic [INTR_WIDTH-1:0]   intr_out,
    output logic                    intr_any
);

    localparam int               CNT_W      = $clog2(SYNC_STAGE + 2);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SYNC_STAGE + 1);
    localparam logic [1:0]       MODE_LEVEL = 2'b00;
    localparam logic [1:0]       MODE_RISE  = 2'b01;
    localparam logic [1:0]       MODE_FALL  = 2'b10;
    localparam logic [1:0]       MODE_BOTH  = 2'b11;

    (* ASYNC_REG = "TRUE" *) logic [INTR_WIDTH-1:0] sync_q [SYNC_STAGE];

    logic [INTR_WIDTH-1:0]      d_q;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [INTR_WIDTH-1:0]      pend_q, pend_d;
    logic [INTR_WIDTH-1:0]      evt_q, evt_d;
    logic [INTR_WIDTH-1:0][1:0] mode_q, mode_d;

    logic [INTR_WIDTH-1:0] sync_s;
    logic [INTR_WIDTH-1:0] rise_w;
    logic [INTR_WIDTH-1:0] fall_w;
    logic [INTR_WIDTH-1:0] edge_w;
    logic [INTR_WIDTH-1:0] mode_chg_w;
    logic                  valid_w;

    assign sync_s  = sync_q[SYNC_STAGE-1];
    assign rise_w  = sync_s & ~d_q;
    assign fall_w  = ~sync_s & d_q;
    assign valid_w = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d      = valid_w ? cnt_q : cnt_q + CNT_W'(1);
        mode_d     = intr_mode;
        pend_d     = pend_q;
        evt_d      = '0;
        edge_w     = '0;
        mode_chg_w = '0;
        for (int i = 0; i < INTR_WIDTH; i++) begin
            mode_chg_w[i] = (intr_mode[2*i +: 2] != mode_q[i]);
            case (mode_q[i])
                MODE_RISE:  edge_w[i] = rise_w[i];
                MODE_FALL:  edge_w[i] = fall_w[i];
                MODE_BOTH:  edge_w[i] = rise_w[i] | fall_w[i];
                default:    edge_w[i] = 1'b0;
            endcase
            evt_d[i] = edge_w[i] & valid_w & ~mode_chg_w[i];
            // A mode switch discards whatever the old mode had captured.
            if (mode_chg_w[i]) begin
                pend_d[i] = 1'b0;
            end else if (mode_q[i] == MODE_LEVEL) begin
                pend_d[i] = sync_s[i] & valid_w;
            end else begin
                pend_d[i] = (pend_q[i] & ~intr_clr[i]) | (edge_w[i] & valid_w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGE; k++) begin
                sync_q[k] <= '0;
            end
            d_q    <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
            evt_q  <= '0;
            mode_q <= intr_mode;
        end else begin
            sync_q[0] <= intr_in;
            for (int k = 1; k < SYNC_STAGE; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            d_q    <= sync_s;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            evt_q  <= evt_d;
            mode_q <= mode_d;
        end
    end

    assign intr_pend = pend_q;
    assign intr_evt  = evt_q;
    assign intr_out  = pend_q & intr_en;
    assign intr_any  = |intr_out;

endmodule

// File: tb/tb_intr_cond_sync.sv
// Bench for intr_cond_sync: directed scenarios plus randomized traffic, all
// checked against a history-based reference model of the conditioner.
module tb_intr_cond_sync;

    localparam int W  = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] intr_in = '0;
    logic [7:0]   intr_mode = 8'h55;
    logic [W-1:0] intr_en = '0;
    logic [W-1:0] intr_clr = '0;
    logic [W-1:0] intr_pend;
    logic [W-1:0] intr_evt;
    logic [W-1:0] intr_out;
    logic         intr_any;

    int n_chk = 0;
    int n_bad = 0;

    intr_cond_sync #(.INTR_WIDTH(W), .SYNC_STAGE(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .intr_in   (intr_in),
        .intr_mode (intr_mode),
        .intr_en   (intr_en),
        .intr_clr  (intr_clr),
        .intr_pend (intr_pend),
        .intr_evt  (intr_evt),
        .intr_out  (intr_out),
        .intr_any  (intr_any)
    );

    always #5 clk = ~clk;

    // Reference model: the synchronised value seen at edge t is simply the
    // input sampled SS edges earlier (zero before reset release).
    logic [W-1:0] hist[$];
    int           t = 0;
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] m_evt = '0;
    logic [7:0]   m_mode = 8'h55;

    function automatic logic [W-1:0] smp(input int k);
        if (k >= 1 && k <= hist.size()) return hist[k-1];
        return '0;
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] s, d;
        logic [1:0]   md;
        logic         ok, e;
        if (rst) begin
            t = 0;
            hist.delete();
            m_pend = '0;
            m_evt  = '0;
            m_mode = intr_mode;
        end else begin
            t++;
            hist.push_back(intr_in);
            s  = smp(t - SS);
            d  = smp(t - SS - 1);
            ok = (t >= SS + 2);
            for (int i = 0; i < W; i++) begin
                md = intr_mode[2*i +: 2];
                case (md)
                    2'b01:   e = s[i] && !d[i];
                    2'b10:   e = !s[i] && d[i];
                    2'b11:   e = s[i] != d[i];
                    default: e = 1'b0;
                endcase
                if (md != m_mode[2*i +: 2]) begin
                    m_pend[i] = 1'b0;
                    m_evt[i]  = 1'b0;
                end else if (md == 2'b00) begin
                    m_pend[i] = s[i] && ok;
                    m_evt[i]  = 1'b0;
                end else begin
                    m_pend[i] = (m_pend[i] && !intr_clr[i]) || (e && ok);
                    m_evt[i]  = e && ok;
                end
            end
            m_mode = intr_mode;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and compare every output with the model on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("pend", 32'(intr_pend), 32'(m_pend));
        chk("evt",  32'(intr_evt),  32'(m_evt));
        chk("out",  32'(intr_out),  32'(m_pend & intr_en));
        chk("any",  32'(intr_any),  32'(|(m_pend & intr_en)));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int hold;
        int evt2_cnt, evt2_first, evt2_last, pend3_cnt, evt3_cnt;

        // Reset with all sources already high in rising mode.
        rst = 1'b1; intr_mode = 8'h55; intr_in = 4'hF; intr_en = 4'hF;
        @(negedge clk);
        ticks(2);
        chk("rst_pend", 32'(intr_pend), 0);
        chk("rst_evt",  32'(intr_evt), 0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("hi_evt", 32'(intr_evt), 0);
            chk("hi_any", 32'(intr_any), 0);
        end

        // Rising detect on ch0 and later clear.
        intr_in = 4'h0;
        ticks(4);
        intr_in = 4'h1;
        tick();
        tick();
        chk("rise_early", 32'(intr_evt[0]), 0);
        tick();
        chk("rise_evt",  32'(intr_evt[0]), 1);
        chk("rise_pend", 32'(intr_pend[0]), 1);
        tick();
        chk("rise_evt_w", 32'(intr_evt[0]), 0);
        chk("rise_hold",  32'(intr_pend[0]), 1);
        ticks(2);
        intr_clr = 4'h1;
        tick();
        intr_clr = 4'h0;
        chk("clr_pend", 32'(intr_pend[0]), 0);

        // Clear colliding with a new event.
        intr_in = 4'h0;
        ticks(3);
        intr_in = 4'h1;
        ticks(4);
        chk("col_pre", 32'(intr_pend[0]), 1);
        intr_in = 4'h0;
        ticks(3);
        intr_in = 4'h1;
        ticks(2);
        intr_clr = 4'h1;
        tick();
        intr_clr = 4'h0;
        chk("col_pend", 32'(intr_pend[0]), 1);
        chk("col_evt",  32'(intr_evt[0]), 1);

        // Masking on ch1 in falling mode.
        intr_clr = 4'hF;
        tick();
        intr_clr = 4'h0;
        intr_en = 4'h0;
        intr_mode = 8'h59;
        intr_in = 4'h3;
        ticks(4);
        intr_in = 4'h1;
        ticks(4);
        chk("msk_pend", 32'(intr_pend), 32'h2);
        chk("msk_out",  32'(intr_out), 0);
        chk("msk_any",  32'(intr_any), 0);
        intr_en = 4'h2;
        #1;
        chk("en_out", 32'(intr_out), 32'h2);
        chk("en_any", 32'(intr_any), 1);
        intr_en = 4'h0;

        // Both-edge on ch2 and level on ch3 with the same 5-cycle pulse.
        intr_mode = 8'h39;
        intr_clr = 4'hF;
        ticks(3);
        intr_clr = 4'h0;
        evt2_cnt = 0; evt2_first = -1; evt2_last = -1; pend3_cnt = 0; evt3_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            if (j == 0) intr_in = 4'hD;
            if (j == 5) intr_in = 4'h1;
            tick();
            if (intr_evt[2]) begin
                evt2_cnt++;
                if (evt2_first < 0) evt2_first = j;
                evt2_last = j;
            end
            if (intr_pend[3]) pend3_cnt++;
            if (intr_evt[3]) evt3_cnt++;
            if (j == 2) chk("lvl_start", 32'(intr_pend[3]), 1);
            if (j == 1) chk("lvl_early", 32'(intr_pend[3]), 0);
        end
        chk("both_cnt", 32'(evt2_cnt), 2);
        chk("both_gap", 32'(evt2_last - evt2_first), 5);
        chk("lvl_len",  32'(pend3_cnt), 5);
        chk("lvl_evt",  32'(evt3_cnt), 0);

        // Mode change clears pend without an event.
        intr_mode = 8'h39;
        intr_in = 4'h0;
        ticks(4);
        intr_in = 4'h1;
        ticks(4);
        chk("mc_pre", 32'(intr_pend[0]), 1);
        intr_mode = 8'h3A;
        tick();
        chk("mc_pend", 32'(intr_pend[0]), 0);
        chk("mc_evt",  32'(intr_evt[0]), 0);

        // Reset mid-operation with everything pending.
        intr_mode = 8'h55;
        intr_in = 4'h0;
        ticks(4);
        intr_in = 4'hF;
        ticks(4);
        chk("mr_pre", 32'(intr_pend), 32'hF);
        intr_en = 4'hF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_pend", 32'(intr_pend), 0);
        chk("mr_any",  32'(intr_any), 0);
        intr_in = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr_evt", 32'(intr_evt), 0);
        end
        ticks(3);

        // Randomized traffic.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                intr_in = 4'($urandom_range(0, 15));
                hold = $urandom_range(2, 6);
            end
            hold--;
            if ($urandom_range(0, 39) == 0) intr_mode = 8'($urandom_range(0, 255));
            intr_en  = 4'($urandom_range(0, 15));
            intr_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        intr_clr = 4'h0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/intr_cond_sync.md
# intr_cond_sync

Multi-channel interrupt conditioner for the `clk` domain, parametrised in channel count and synchroniser depth. It takes asynchronous interrupt lines from peripherals or other clock domains and synchronises them. Per channel, it applies a selectable detect mode (level, rising, falling or both edges), holds edge events in a pending register with write-1-to-clear, and masks the result into per-channel and aggregate interrupt outputs. It sits between raw interrupt sources and the interrupt controller input.

## Interface
- `INTR_WIDTH`, 4, number of channels (≥1)
- `SYNC_STAGE`, 2, synchroniser flop stages per channel (≥2)

- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `intr_in`  in  INTR_WIDTH  asynchronous interrupt sources
- `intr_mode`  in  2*INTR_WIDTH  per-channel mode, bits [2i+1:2i]:
  - 00: level-high
  - 01: rising edge
  - 10: falling edge
  - 11: both edges
  - quasi-static
- `intr_en`  in  INTR_WIDTH  per-channel output enable (mask)
- `intr_clr`  in  INTR_WIDTH  write-1-to-clear pending, one-cycle pulses, synchronous to `clk`
- `intr_pend`  out  INTR_WIDTH  pending status (unmasked)
- `intr_evt`  out  INTR_WIDTH  one-cycle detected-event strobe (unmasked)
- `intr_out`  out  INTR_WIDTH  `intr_pend & intr_en`
- `intr_any`  out  1  OR-reduction of `intr_out`

## Operation
- **Synchroniser:** `SYNC_STAGE` flops per channel, all carrying the `ASYNC_REG` attribute; the last stage is `s`. Pulses shorter than one `clk` period may be missed; sources must hold ≥2 `clk` periods.
- **Previous-value register:** `d <= s` each cycle.
- **Edge terms:** `rise = s & ~d`, `fall = ~s & d`.
- **Event by mode:**
  - 01: `rise`
  - 10: `fall`
  - 11: `rise | fall`
  - 00: no event; `intr_evt` stays 0
- **Settle counter:** shared, width `clog2(SYNC_STAGE+2)`.
  - Reset to 0; increments each non-reset cycle and saturates at `SYNC_STAGE+1`.
  - `valid = (cnt == SYNC_STAGE+1)`.
  - While `!valid`, all events are suppressed and level-mode pend is forced to 0.
  - No spurious event is produced from sources already high at reset release.
- **Pending, level mode:** `pend <= s & valid`; `intr_clr` is ignored.
- **Pending, edge modes:** `pend <= (pend & ~clr) | (evt & valid)`. Set wins over a simultaneous clear, so no interrupt is lost.
- **Mode tracking:** the mode is registered per channel (`mode_q`). When `intr_mode` differs from `mode_q`, that cycle:
  - pend is cleared,
  - the event is suppressed,
  - `mode_q` is updated.
- **Event strobe:** `intr_evt <= evt & valid & (mode == mode_q)`.
- **Masking:** `intr_en` never affects capture into pend. `intr_out` and `intr_any` are combinational from the pend and `intr_en` registers.

## Timing
- **Reset:** synchronous. At the first edge with `rst=1`, all of the following go to 0:
  - sync flops, `d`, `cnt`, pend, `intr_evt`
  - `mode_q`, which is loaded from `intr_mode` instead
- Outputs are 0 from that edge. Reset mid-operation discards pending state and re-runs settling.
- **Latency:** let edge N be the first edge sampling the new `intr_in` value.
  - `intr_evt` and `intr_pend` update at edge N+`SYNC_STAGE`.
  - `intr_out` follows in the same cycle.
  - `intr_evt` is exactly one cycle wide per event.
- **Clear:** `intr_clr` asserted at edge M deasserts pend at edge M, unless an event is also registered at M.
- **First reportable update:** edge `SYNC_STAGE+2` after reset release.
- Channels are fully independent, apart from the shared settle counter.

## Test plan
All scenarios use `INTR_WIDTH=4`, `SYNC_STAGE=2`.

- **Reset with sources high:** `intr_mode=8'h55` (all rising), `intr_in=4'hF` held through and after reset -> `intr_evt`, `intr_pend` and `intr_any` remain 0 indefinitely.
- **Rising detect:** ch0 rising mode, `intr_in[0]` 0->1 first sampled at edge N -> `intr_evt[0]` is 1 for exactly the cycle after edge N+2; `intr_pend[0]=1` from N+2 until cleared. `intr_clr[0]` at a later edge M -> pend 0 after M.
- **Clear vs. event collision:** edge-mode channel with pend=1; `intr_clr` pulse on the same edge a new event registers -> pend stays 1 and `intr_evt` pulses.
- **Masking:** ch1 falling mode, `intr_en=4'b0000`, falling edge on ch1 -> `intr_pend=4'b0010`, `intr_out=0`, `intr_any=0`. Then set `intr_en[1]=1` -> `intr_out=4'b0010` and `intr_any=1` in the same cycle.
- **Both-edge and level modes:**
  - ch2 mode 11, 5-cycle high pulse -> two `intr_evt[2]` strobes 5 cycles apart.
  - ch3 mode 00, same pulse -> `intr_pend[3]` high for 5 cycles, delayed 2 cycles from the input; `intr_evt[3]` stays 0.
- **Mode change and reset mid-operation:**
  - ch0 pending; change ch0 mode 01->10 -> pend[0] cleared next edge with no evt.
  - Then set pend on ch0–ch3 and assert `rst` for one cycle -> all outputs 0 at that edge, and no event is reported before edge 4 after release.
